// File: rtl/regs_debug_scanner_if.sv
// Byte stream from the scanner to its sink: valid/ready handshake carrying
// one byte per accepted transfer.
interface regs_debug_scanner_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regs_debug_scanner.sv
// Register file debug scanner: on start, walks register indices 0..LAST_REG
// through the debug read port and streams a framed dump. The frame is the
// HEADER byte followed by one 5-byte record per register: the index, then the
// 32-bit value little-endian. Each register is sampled in its own LOAD cycle.
module regs_debug_scanner #(
  parameter logic [7:0] HEADER   = 8'hA5,
  parameter int         LAST_REG = 31
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [4:0]                   dbg_addr,
  input  logic [31:0]                  dbg_data,
  regs_debug_scanner_if.master         tx,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(LAST_REG);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  idx;
  logic [2:0]  cnt;
  logic [31:0] held;
  logic [7:0]  rec_byte;
  logic        last_byte;
  logic        last_reg;

  assign dbg_addr  = idx;
  assign last_byte = (cnt == 3'd4);
  assign last_reg  = (idx == LAST_IDX);

  // State register; reset returns to IDLE and abandons any frame in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Select the record byte: index first, then the held value LSB first.
  always_comb begin
    rec_byte = 8'h00;
    case (cnt)
      3'd0:    rec_byte = {3'b000, idx};
      3'd1:    rec_byte = held[7:0];
      3'd2:    rec_byte = held[15:8];
      3'd3:    rec_byte = held[23:16];
      3'd4:    rec_byte = held[31:24];
      default: rec_byte = 8'h00;
    endcase
  end

  // Next-state and outputs. Outputs depend on state only, so data/valid stay
  // stable while the sink stalls.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_nxt   = state;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = HDR;
      end
      HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = HEADER;
        if (tx.tx_ready) state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = rec_byte;
        if (tx.tx_ready && last_byte) state_nxt = last_reg ? DONE : LOAD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan datapath: register index, byte counter and the holding register.
  always_ff @(posedge clk) begin
    // NOTE: the holding register is reset too, since its contents reach
    // tx_data and a clean post-reset state is part of the contract.
    if (!rst) begin
      idx  <= 5'd0;
      cnt  <= 3'd0;
      held <= 32'd0;
    end else begin
      case (state)
        LOAD: begin
          held <= dbg_data;
          cnt  <= 3'd0;
        end
        SEND: begin
          if (tx.tx_ready) begin
            if (last_byte) begin
              cnt <= 3'd0;
              idx <= last_reg ? 5'd0 : idx + 5'd1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        DONE: idx <= 5'd0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regs_debug_scanner.sv
// Bench for regs_debug_scanner: a behavioural register file drives the debug
// port, the expected frame is built from the register contents, and the
// observed byte stream, done timing and stall behaviour are compared.
module tb_regs_debug_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic        tx_ready;
  logic [4:0]  dbg_addr0, dbg_addr1;
  logic [31:0] dbg_data0, dbg_data1;
  logic        busy0, busy1, done0, done1;

  logic [31:0] regs [32];

  regs_debug_scanner_if bus0 ();
  regs_debug_scanner_if bus1 ();

  assign bus0.tx_ready = tx_ready;
  assign bus1.tx_ready = tx_ready;
  assign dbg_data1 = (dbg_addr1 == 5'd0) ? 32'd0 : regs[dbg_addr1];
  assign dbg_data0 = (dbg_addr0 == 5'd0) ? 32'd0 : regs[dbg_addr0];

  regs_debug_scanner dut1 (
    .clk(clk), .rst(rst), .start(start1), .dbg_addr(dbg_addr1),
    .dbg_data(dbg_data1), .tx(bus1.master), .busy(busy1), .done(done1)
  );

  regs_debug_scanner #(.HEADER(8'hA5), .LAST_REG(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .dbg_addr(dbg_addr0),
    .dbg_data(dbg_data0), .tx(bus0.master), .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  bit   sel = 1'b1;
  bit   rst_level = 1'b0;
  bit   start_level = 1'b0;
  int   ready_pct = 100;
  int   cyc = 0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic       s_valid, s_busy, s_done;
  logic [7:0] s_data;
  logic [4:0] s_addr;

  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];
  int         done_q[$];
  int         t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_model(input int k);
    return (k == 0) ? 32'd0 : regs[k];
  endfunction

  // Expected frame: header, then per register its index and value LSB first.
  task automatic build_exp(input int last);
    logic [31:0] v;
    exp_q.push_back(8'hA5);
    for (int k = 0; k <= last; k++) begin
      v = reg_model(k);
      exp_q.push_back(8'(k));
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(v >> (8 * b)));
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then sample.
  task automatic tick();
    @(negedge clk);
    rst      = rst_level;
    tx_ready = ($urandom_range(99) < ready_pct);
    start1   = sel ? start_level : 1'b0;
    start0   = sel ? 1'b0 : start_level;
    #1;
    s_valid = sel ? bus1.tx_valid : bus0.tx_valid;
    s_data  = sel ? bus1.tx_data  : bus0.tx_data;
    s_busy  = sel ? busy1 : busy0;
    s_done  = sel ? done1 : done0;
    s_addr  = sel ? dbg_addr1 : dbg_addr0;
    if (prev_stall) begin
      check("stall_valid", 32'(s_valid), 32'd1);
      check("stall_data", 32'(s_data), 32'(prev_data));
    end
    if (!sel) check("l0_dbg_addr", 32'(s_addr), 32'd0);
    if (s_valid === 1'b1 && tx_ready) byte_q.push_back(s_data);
    if (s_done === 1'b1) done_q.push_back(cyc);
    prev_stall = (s_valid === 1'b1) && !tx_ready && rst_level;
    prev_data  = s_data;
    cyc++;
  endtask

  // Pulse start for one cycle, then run until the first done or the budget.
  task automatic run_scan(input int budget, input bit write_at5);
    int n;
    bit written;
    written = 1'b0;
    byte_q.delete();
    done_q.delete();
    start_level = 1'b1;
    tick();
    t0 = cyc - 1;
    start_level = 1'b0;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      tick();
      if (write_at5 && !written && s_addr === 5'd5) begin
        regs[31] = 32'hDEADBEEF;
        written = 1'b1;
      end
      n++;
    end
    check("done_seen", 32'(done_q.size()), 32'd1);
    if (write_at5) check("write_at_idx5", 32'(written), 32'd1);
  endtask

  task automatic compare_frame(input string tag);
    int n;
    check({tag, "_len"}, 32'(byte_q.size()), 32'(exp_q.size()));
    n = (byte_q.size() < exp_q.size()) ? byte_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(byte_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    tx_ready = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;

    // Reset state.
    rst_level = 1'b0;
    tick();
    tick();
    rst_level = 1'b1;
    tick();
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_data", 32'(s_data), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_done", 32'(s_done), 32'd0);
    check("rst_addr", 32'(s_addr), 32'd0);

    // Single known register, sink always ready: frame content and latency.
    regs[1] = 32'h11223344;
    ready_pct = 100;
    run_scan(1000, 1'b0);
    exp_q.delete();
    build_exp(31);
    compare_frame("r1_frame");
    check("r1_frame_total", 32'(byte_q.size()), 32'd161);
    check("r1_latency", 32'(done_q.size() ? done_q[0] - t0 : -1), 32'd194);
    tick();
    check("r1_done_one_cycle", 32'(s_done), 32'd0);
    check("r1_idle_busy", 32'(s_busy), 32'd0);

    // Same registers with a stalling sink: identical bytes, stable while stalled.
    ready_pct = 30;
    run_scan(3000, 1'b0);
    compare_frame("r1_stall_frame");

    // Random register contents with a moderately stalling sink.
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    ready_pct = 60;
    run_scan(2000, 1'b0);
    exp_q.delete();
    build_exp(31);
    compare_frame("rand_frame");

    // Start held high: back-to-back frames 195 cycles apart.
    ready_pct = 100;
    byte_q.delete();
    done_q.delete();
    start_level = 1'b1;
    tick();
    t0 = cyc - 1;
    for (int i = 1; i < 400; i++) tick();
    start_level = 1'b0;
    for (int i = 0; i < 1000 && done_q.size() < 3; i++) tick();
    check("held_done_count", 32'(done_q.size()), 32'd3);
    if (done_q.size() >= 3) begin
      check("held_first_latency", 32'(done_q[0] - t0), 32'd194);
      check("held_gap1", 32'(done_q[1] - done_q[0]), 32'd195);
      check("held_gap2", 32'(done_q[2] - done_q[1]), 32'd195);
    end
    exp_q.delete();
    build_exp(31);
    build_exp(31);
    build_exp(31);
    compare_frame("held_frames");

    // Reset while sending register 7 byte 2.
    exp_q.delete();
    build_exp(31);
    byte_q.delete();
    done_q.delete();
    start_level = 1'b1;
    tick();
    start_level = 1'b0;
    for (int i = 0; i < 500 && byte_q.size() < 38; i++) tick();
    check("mid_reach_reg7", 32'(byte_q.size()), 32'd38);
    rst_level = 1'b0;
    tick();
    check("mid_byte_before_rst", 32'(s_data), 32'(exp_q[38]));
    rst_level = 1'b1;
    tick();
    check("mid_rst_valid", 32'(s_valid), 32'd0);
    check("mid_rst_busy", 32'(s_busy), 32'd0);
    check("mid_rst_addr", 32'(s_addr), 32'd0);
    byte_q.delete();
    for (int i = 0; i < 20; i++) tick();
    check("mid_no_bytes", 32'(byte_q.size()), 32'd0);
    run_scan(1000, 1'b0);
    compare_frame("post_rst_frame");

    // Write to register 31 while index 5 is being scanned.
    regs[31] = 32'h0;
    run_scan(1000, 1'b1);
    exp_q.delete();
    build_exp(31);
    compare_frame("late_write_frame");
    if (byte_q.size() == 161) begin
      check("r31_b0", 32'(byte_q[157]), 32'hEF);
      check("r31_b3", 32'(byte_q[160]), 32'hDE);
    end

    // Single-register instance: 6-byte frame, done 8 cycles after start.
    sel = 1'b0;
    prev_stall = 1'b0;
    ready_pct = 100;
    run_scan(200, 1'b0);
    exp_q.delete();
    build_exp(0);
    compare_frame("l0_frame");
    check("l0_latency", 32'(done_q.size() ? done_q[0] - t0 : -1), 32'd8);
    tick();
    check("l0_idle_busy", 32'(s_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
